// File: rtl/contador_pkg.sv
// contador_pkg: shared types and defaults for the multichannel counter.
// Holds the per-channel state encoding and default geometry.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2
    } estado_t;

    localparam int WIDTH_DEF    = 6;
    localparam int CHANNELS_DEF = 2;

endpackage

// File: rtl/contador_canal.sv
// contador_canal: one up/down counter channel with wrap or saturate,
// a delayed terminal-count pulse and a sticky natural-rollover flag.
module contador_canal
    import contador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_term,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    estado_t          state, state_d;
    logic [WIDTH-1:0] count_d, term, nxt;
    logic             tc_d, ovf_d, hit, hit_d, nxt_ovf;

    assign term = dir ? limit : '0;

    // Wrap-mode step result; saturation is decided in the FSM.
    always_comb begin
        nxt     = count;
        nxt_ovf = 1'b0;
        if (dir) begin
            if (count == limit) begin
                nxt = '0;
            end else if (count == '1) begin
                nxt     = '0;
                nxt_ovf = 1'b1;
            end else begin
                nxt = count + ONE;
            end
        end else begin
            if (count == '0) nxt = limit;
            else             nxt = count - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            hit   <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            tc    <= tc_d;
            ovf   <= ovf_d;
            hit   <= hit_d;
        end
    end

    // hit marks a step that landed on the terminal; tc shows it one cycle later.
    always_comb begin
        state_d = state;
        count_d = count;
        ovf_d   = ovf;
        tc_d    = 1'b0;
        hit_d   = 1'b0;
        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            state_d = IDLE;
            count_d = load_val;
        end else begin
            tc_d = hit;
            unique case (state)
                HELD: ;
                IDLE, RUN: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (sat && count == term) begin
                        state_d = HELD;
                    end else begin
                        count_d = nxt;
                        ovf_d   = ovf | nxt_ovf;
                        hit_d   = (nxt == term);
                        state_d = (sat && nxt == term) ? HELD : RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        at_term = (count == term);
    end

endmodule

// File: rtl/contador_multicanal.sv
// contador_multicanal: CHANNELS independent counter channels
// sharing one clock and reset, with packed per-channel buses.
module contador_multicanal
    import contador_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       sat,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       at_term,
    output logic [CHANNELS-1:0]       ovf
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_canal
        contador_canal #(
            .WIDTH(WIDTH)
        ) u_canal (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr[i]),
            .load    (load[i]),
            .load_val(load_val[i*WIDTH +: WIDTH]),
            .limit   (limit[i*WIDTH +: WIDTH]),
            .enable  (enable[i]),
            .dir     (dir[i]),
            .sat     (sat[i]),
            .count   (count[i*WIDTH +: WIDTH]),
            .tc      (tc[i]),
            .at_term (at_term[i]),
            .ovf     (ovf[i])
        );
    end

endmodule

// File: tb/tb_contador_multicanal.sv
// tb_contador_multicanal: directed table, corner sequences and random
// stimulus against a behavioural per-channel model.
module tb_contador_multicanal;

    localparam int W = 6;
    localparam int N = 2;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   clr, load, enable, dir, sat;
    logic [N*W-1:0] load_val, limit;
    logic [N*W-1:0] count;
    logic [N-1:0]   tc, at_term, ovf;

    int errors = 0;
    int checks = 0;

    int m_c[N];
    bit m_ovf[N], m_tc[N], m_hit[N], m_held[N];

    typedef struct {
        bit en;
        int lim;
        int exp_count;
        bit exp_tc;
    } vec_t;

    always #5 clk = ~clk;

    contador_multicanal #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_val(load_val), .limit(limit), .enable(enable),
        .dir(dir), .sat(sat), .count(count), .tc(tc),
        .at_term(at_term), .ovf(ovf)
    );

    task automatic chk(string name, int ch, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d expected %0d", name, ch, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            m_c[ch] = 0; m_ovf[ch] = 0; m_tc[ch] = 0;
            m_hit[ch] = 0; m_held[ch] = 0;
        end
    endtask

    // Applies the edge rules to the model using the inputs present now.
    task automatic model_step();
        for (int ch = 0; ch < N; ch++) begin
            int lim, t, nx;
            lim = int'(limit[ch*W +: W]);
            t = dir[ch] ? lim : 0;
            if (clr[ch]) begin
                m_c[ch] = 0; m_ovf[ch] = 0; m_tc[ch] = 0;
                m_hit[ch] = 0; m_held[ch] = 0;
            end else if (load[ch]) begin
                m_c[ch] = int'(load_val[ch*W +: W]);
                m_tc[ch] = 0; m_hit[ch] = 0; m_held[ch] = 0;
            end else begin
                m_tc[ch] = m_hit[ch];
                m_hit[ch] = 0;
                if (enable[ch] && !m_held[ch]) begin
                    if (sat[ch] && m_c[ch] == t) begin
                        m_held[ch] = 1;
                    end else begin
                        if (dir[ch]) begin
                            if (m_c[ch] == lim) nx = 0;
                            else begin
                                nx = (m_c[ch] + 1) % M;
                                if (m_c[ch] + 1 == M) m_ovf[ch] = 1;
                            end
                        end else begin
                            nx = (m_c[ch] == 0) ? lim : m_c[ch] - 1;
                        end
                        m_c[ch] = nx;
                        m_hit[ch] = (nx == t);
                        if (sat[ch] && nx == t) m_held[ch] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int ch = 0; ch < N; ch++) begin
            int t;
            t = dir[ch] ? int'(limit[ch*W +: W]) : 0;
            chk("count", ch, 32'(count[ch*W +: W]), m_c[ch]);
            chk("tc", ch, 32'(tc[ch]), 32'(m_tc[ch]));
            chk("ovf", ch, 32'(ovf[ch]), 32'(m_ovf[ch]));
            chk("at_term", ch, 32'(at_term[ch]), 32'(m_c[ch] == t));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        #1 reset = 1'b0;
    endtask

    task automatic set_ch(int ch, logic [W-1:0] lv, logic [W-1:0] lim);
        load_val[ch*W +: W] = lv;
        limit[ch*W +: W] = lim;
    endtask

    vec_t tbl[10];
    int   tcs;
    int   e0[4], e1[4];

    initial begin
        reset = 1'b1;
        clr = '0; load = '0; enable = '0; dir = '0; sat = '0;
        load_val = '0; limit = '0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // Up count, limit 5, wrap; tc trails the count=5 cycle.
        tbl[0] = '{1, 5, 1, 0}; tbl[1] = '{1, 5, 2, 0};
        tbl[2] = '{1, 5, 3, 0}; tbl[3] = '{1, 5, 4, 0};
        tbl[4] = '{1, 5, 5, 0}; tbl[5] = '{1, 5, 0, 1};
        tbl[6] = '{1, 5, 1, 0}; tbl[7] = '{1, 5, 2, 0};
        tbl[8] = '{0, 5, 2, 0}; tbl[9] = '{0, 5, 2, 0};
        dir[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enable[0] = tbl[i].en;
            set_ch(0, '0, W'(tbl[i].lim));
            cycle();
            chk("tbl_count", i, 32'(count[W-1:0]), tbl[i].exp_count);
            chk("tbl_tc", i, 32'(tc[0]), 32'(tbl[i].exp_tc));
        end

        // Down, saturate: held at 0, one tc pulse, load releases.
        enable = '0;
        dir[1] = 1'b0; sat[1] = 1'b1; load[1] = 1'b1;
        set_ch(1, 6'd3, 6'd7);
        cycle();
        chk("sat_load", 1, 32'(count[2*W-1:W]), 3);
        load[1] = 1'b0; enable[1] = 1'b1;
        tcs = 0;
        e0 = '{2, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            cycle();
            tcs += int'(tc[1]);
            if (i < 4) chk("sat_seq", 1, 32'(count[2*W-1:W]), e0[i]);
        end
        chk("sat_tc_once", 1, tcs, 1);
        sat[1] = 1'b0;
        cycle(); cycle();
        chk("held", 1, 32'(count[2*W-1:W]), 0);
        enable[1] = 1'b0; load[1] = 1'b1;
        set_ch(1, 6'd4, 6'd7);
        cycle();
        chk("held_load", 1, 32'(count[2*W-1:W]), 4);
        load[1] = 1'b0; enable[1] = 1'b1;
        cycle();
        chk("after_held", 1, 32'(count[2*W-1:W]), 3);
        enable[1] = 1'b0;

        // Loaded above limit: rolls 63->0 with sticky ovf until clr.
        clr[0] = 1'b1; cycle(); clr[0] = 1'b0;
        dir[0] = 1'b1; sat[0] = 1'b0; load[0] = 1'b1;
        set_ch(0, 6'd62, 6'd10);
        cycle();
        load[0] = 1'b0; enable[0] = 1'b1;
        e0 = '{63, 0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ovf_seq", 0, 32'(count[W-1:0]), e0[i]);
        end
        chk("ovf_set", 0, 32'(ovf[0]), 1);
        for (int i = 0; i < 12; i++) cycle();
        chk("ovf_sticky", 0, 32'(ovf[0]), 1);
        clr[0] = 1'b1; cycle(); clr[0] = 1'b0;
        chk("ovf_clr", 0, 32'(ovf[0]), 0);

        // Priority on the same edge.
        load[0] = 1'b1; set_ch(0, 6'd63, 6'd10);
        cycle(); load[0] = 1'b0;
        cycle();
        clr[0] = 1'b1; load[0] = 1'b1; set_ch(0, 6'd20, 6'd10);
        cycle();
        chk("prio_clr", 0, 32'(count[W-1:0]), 0);
        chk("prio_ovf", 0, 32'(ovf[0]), 0);
        clr[0] = 1'b0;
        cycle();
        chk("prio_load", 0, 32'(count[W-1:0]), 20);
        load[0] = 1'b0;

        // Asynchronous reset mid-run at count 4.
        clr[0] = 1'b1; cycle(); clr[0] = 1'b0;
        set_ch(0, 6'd0, 6'd20);
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_reset", 0, 32'(count[W-1:0]), 4);
        async_reset();
        chk("async_rst", 0, 32'(count[W-1:0]), 0);
        cycle();
        chk("post_reset", 0, 32'(count[W-1:0]), 1);

        // Two channels counting in opposite directions.
        enable = '0; clr = '1; cycle(); clr = '0;
        dir = 2'b01; sat = '0;
        set_ch(0, 6'd0, 6'd3); set_ch(1, 6'd0, 6'd7);
        enable = '1;
        e0 = '{1, 2, 3, 0}; e1 = '{7, 6, 5, 4};
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("indep0", 0, 32'(count[W-1:0]), e0[i]);
            chk("indep1", 1, 32'(count[2*W-1:W]), e1[i]);
        end

        // limit 0 up wrap: stays 0, tc every enabled cycle.
        enable = '0; clr[0] = 1'b1; cycle(); clr[0] = 1'b0;
        set_ch(0, 6'd0, 6'd0); enable[0] = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lim0_tc", 0, 32'(tc[0]), 1);
        end

        // Random stimulus against the model.
        for (int n = 0; n < 500; n++) begin
            for (int ch = 0; ch < N; ch++) begin
                clr[ch] = ($urandom_range(19) == 0);
                load[ch] = ($urandom_range(9) == 0);
                enable[ch] = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) dir[ch] = $urandom_range(1);
                if ($urandom_range(7) == 0) sat[ch] = ($urandom_range(3) == 0);
                if ($urandom_range(9) == 0)
                    limit[ch*W +: W] = W'($urandom_range(M - 1));
                load_val[ch*W +: W] = W'($urandom_range(M - 1));
            end
            if (n == 250) async_reset();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
